dac_spi_arbiter: RTL and testbench

Two-channel arbiter that shares a single SPI DAC write engine between two sample requesters (channel A and channel B). It accepts 12-bit samples through a request/acknowledge handshake, grants the engine round-robin, and builds the 16-bit DAC frame as {control nibble, sample}. It issues the one-cycle write strobe and acknowledges the requester when the engine reports end-of-write. It sits between the sample sources (sine ROM sequencers, one per DAC output) and the SPI write module, replacing the direct FSM-to-writer connection when both DAC outputs are driven.

---
 rtl/dac_spi_arbiter_if.sv | 26 ++
 rtl/dac_spi_arbiter.sv | 92 +++++++++
 tb/tb_dac_spi_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_arbiter_if.sv
// Handshake bundle shared by the two sample requesters, the arbiter and the SPI DAC writer.
// The arbiter connects through the slave modport; the master side drives requests and eow_i.
interface dac_spi_arbiter_if;
    logic        req_a_i;
    logic [11:0] din_a_i;
    logic        ack_a_o;
    logic        req_b_i;
    logic [11:0] din_b_i;
    logic        ack_b_o;
    logic        strw_o;
    logic [15:0] din_o;
    logic        eow_i;
    logic        grant_o;
    logic        busy_o;
    logic        err_o;

    modport slave (
        input  req_a_i, din_a_i, req_b_i, din_b_i, eow_i,
        output ack_a_o, ack_b_o, strw_o, din_o, grant_o, busy_o, err_o
    );

    modport master (
        output req_a_i, din_a_i, req_b_i, din_b_i, eow_i,
        input  ack_a_o, ack_b_o, strw_o, din_o, grant_o, busy_o, err_o
    );
endinterface

// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one SPI DAC write engine between two 12-bit sample requesters.
// Builds {control nibble, sample} frames, strobes the writer and acknowledges on end-of-write.
module dac_spi_arbiter #(
    parameter logic [3:0]  CTRL_A = 4'b1011,
    parameter logic [3:0]  CTRL_B = 4'b1111,
    parameter logic [15:0] TMAX   = 16'd1023
) (
    input logic              clk_i,
    input logic              rst_i,
    dac_spi_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ACK
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic        last_b;
    logic        pick_b;

    // On a tie the channel not served last wins; otherwise whichever is requesting.
    always_comb begin
        pick_b = bus.req_b_i;
        if (bus.req_a_i && bus.req_b_i) begin
            pick_b = ~last_b;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            count       <= 16'd0;
            last_b      <= 1'b1;
            bus.strw_o  <= 1'b0;
            bus.din_o   <= 16'h0000;
            bus.ack_a_o <= 1'b0;
            bus.ack_b_o <= 1'b0;
            bus.grant_o <= 1'b0;
            bus.busy_o  <= 1'b0;
            bus.err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_a_i || bus.req_b_i) begin
                        bus.din_o   <= pick_b ? {CTRL_B, bus.din_b_i} : {CTRL_A, bus.din_a_i};
                        bus.grant_o <= pick_b;
                        bus.strw_o  <= 1'b1;
                        bus.busy_o  <= 1'b1;
                        count       <= 16'd0;
                        state       <= START;
                    end
                end
                START: begin
                    bus.strw_o <= 1'b0;
                    state      <= WAIT;
                end
                // End-of-write takes priority over a watchdog expiry in the same cycle.
                WAIT: begin
                    if (bus.eow_i) begin
                        bus.ack_a_o <= ~bus.grant_o;
                        bus.ack_b_o <= bus.grant_o;
                        bus.err_o   <= 1'b0;
                        state       <= ACK;
                    end else if (count == TMAX) begin
                        bus.ack_a_o <= ~bus.grant_o;
                        bus.ack_b_o <= bus.grant_o;
                        bus.err_o   <= 1'b1;
                        state       <= ACK;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                ACK: begin
                    bus.ack_a_o <= 1'b0;
                    bus.ack_b_o <= 1'b0;
                    bus.err_o   <= 1'b0;
                    bus.busy_o  <= 1'b0;
                    last_b      <= bus.grant_o;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Self-checking bench for dac_spi_arbiter: a directed transaction table, reset-in-WAIT sequence,
// and a randomized phase checked against a timestamp-based transaction model.
module tb_dac_spi_arbiter;

    localparam logic [15:0] TMAX   = 16'd10;
    localparam int          TMAX_I = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dac_spi_arbiter_if bus();

    dac_spi_arbiter #(.TMAX(TMAX)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        req_a;
        logic        req_b;
        logic [11:0] din_a;
        logic [11:0] din_b;
        int          eow_at;
        logic        grant;
        logic [15:0] frame;
        int          ack_at;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    int          free_at, strw_at, ack_at, wait_start, eow_plan;
    logic        model_last_b, model_err, new_g, old_g, pick_b, in_wait;
    logic        pend_a, pend_b;
    logic [15:0] new_frame, old_frame;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, " strw"}, bus.strw_o, 1'b0);
        check_word({tag, " din_o"}, bus.din_o, 16'h0000);
        check_bit({tag, " ack_a"}, bus.ack_a_o, 1'b0);
        check_bit({tag, " ack_b"}, bus.ack_b_o, 1'b0);
        check_bit({tag, " grant"}, bus.grant_o, 1'b0);
        check_bit({tag, " busy"}, bus.busy_o, 1'b0);
        check_bit({tag, " err"}, bus.err_o, 1'b0);
    endtask

    // Runs one transfer starting in an IDLE cycle; offsets are counted from the strw_o cycle.
    task automatic run_vec(input vec_t v, input int idx);
        bus.req_a_i = v.req_a;
        bus.req_b_i = v.req_b;
        bus.din_a_i = v.din_a;
        bus.din_b_i = v.din_b;
        bus.eow_i   = 1'b1;
        tick();
        check_word($sformatf("v%0d frame", idx), bus.din_o, v.frame);
        check_bit($sformatf("v%0d grant", idx), bus.grant_o, v.grant);
        for (int t = 0; t <= v.ack_at; t++) begin
            check_bit($sformatf("v%0d strw t%0d", idx, t), bus.strw_o, t == 0);
            check_bit($sformatf("v%0d busy t%0d", idx, t), bus.busy_o, 1'b1);
            check_bit($sformatf("v%0d ack_a t%0d", idx, t), bus.ack_a_o, (t == v.ack_at) && !v.grant);
            check_bit($sformatf("v%0d ack_b t%0d", idx, t), bus.ack_b_o, (t == v.ack_at) && v.grant);
            check_bit($sformatf("v%0d err t%0d", idx, t), bus.err_o, (t == v.ack_at) && v.err);
            bus.eow_i = (t == 0) || (t == v.eow_at);
            tick();
        end
        bus.eow_i   = 1'b0;
        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b0;
        check_bit($sformatf("v%0d idle busy", idx), bus.busy_o, 1'b0);
        check_bit($sformatf("v%0d idle strw", idx), bus.strw_o, 1'b0);
        check_bit($sformatf("v%0d idle ack", idx), bus.ack_a_o | bus.ack_b_o, 1'b0);
        check_word($sformatf("v%0d idle frame hold", idx), bus.din_o, v.frame);
    endtask

    initial begin
        // req_a req_b din_a din_b eow_at | grant frame ack_at err
        vecs[0]  = '{1'b1, 1'b1, 12'h111, 12'h222, 1,  1'b0, 16'hB111, 2,  1'b0};
        vecs[1]  = '{1'b1, 1'b1, 12'h111, 12'h222, 1,  1'b1, 16'hF222, 2,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 12'h111, 12'h222, 3,  1'b0, 16'hB111, 4,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, 12'h111, 12'h222, 2,  1'b1, 16'hF222, 3,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 12'hABC, 12'h000, 5,  1'b0, 16'hBABC, 6,  1'b0};
        vecs[5]  = '{1'b0, 1'b1, 12'h000, 12'h5A5, 1,  1'b1, 16'hF5A5, 2,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 12'h000, 12'h0FF, 4,  1'b1, 16'hF0FF, 5,  1'b0};
        vecs[7]  = '{1'b0, 1'b1, 12'h000, 12'h800, 2,  1'b1, 16'hF800, 3,  1'b0};
        vecs[8]  = '{1'b1, 1'b0, 12'h123, 12'h000, -1, 1'b0, 16'hB123, 12, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 12'h456, 12'h000, 11, 1'b0, 16'hB456, 12, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 12'h000, 12'hFFF, 10, 1'b1, 16'hFFFF, 11, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 12'h000, 12'h001, 1,  1'b0, 16'hB000, 2,  1'b0};
        vecs[12] = '{1'b1, 1'b1, 12'h000, 12'h001, 1,  1'b1, 16'hF001, 2,  1'b0};

        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b0;
        bus.din_a_i = 12'h000;
        bus.din_b_i = 12'h000;
        bus.eow_i   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of WAIT aborts without an ack; a tie afterwards goes to A.
        bus.req_a_i = 1'b1;
        bus.req_b_i = 1'b1;
        bus.din_a_i = 12'h3C3;
        bus.din_b_i = 12'h7E7;
        tick();
        tick();
        tick();
        check_bit("abort busy", bus.busy_o, 1'b1);
        rst = 1'b1;
        tick();
        check_reset_values("abort");
        rst = 1'b0;
        run_vec('{1'b1, 1'b1, 12'h3C3, 12'h7E7, 2, 1'b0, 16'hB3C3, 3, 1'b0}, 99);

        // Randomized phase: the model predicts each transfer's strobe, wait window and ack times.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        free_at      = 0;
        strw_at      = -1;
        ack_at       = -1;
        wait_start   = -1;
        eow_plan     = -1;
        model_last_b = 1'b1;
        model_err    = 1'b0;
        new_g        = 1'b0;
        old_g        = 1'b0;
        new_frame    = 16'h0000;
        old_frame    = 16'h0000;
        pend_a       = 1'b0;
        pend_b       = 1'b0;
        for (int n = 0; n < 600; n++) begin
            check_bit("rnd strw", bus.strw_o, n == strw_at);
            check_bit("rnd busy", bus.busy_o, (n >= strw_at) && (n <= ack_at));
            check_bit("rnd ack_a", bus.ack_a_o, (n == ack_at) && !new_g);
            check_bit("rnd ack_b", bus.ack_b_o, (n == ack_at) && new_g);
            check_bit("rnd err", bus.err_o, (n == ack_at) && model_err);
            check_word("rnd din_o", bus.din_o, (n >= strw_at) ? new_frame : old_frame);
            check_bit("rnd grant", bus.grant_o, (n >= strw_at) ? new_g : old_g);

            if (n == ack_at + 1) begin
                if (new_g) pend_b = 1'b0;
                else       pend_a = 1'b0;
            end
            if (!pend_a && $urandom_range(0, 2) == 0) begin
                pend_a      = 1'b1;
                bus.din_a_i = 12'($urandom);
            end
            if (!pend_b && $urandom_range(0, 2) == 0) begin
                pend_b      = 1'b1;
                bus.din_b_i = 12'($urandom);
            end
            bus.req_a_i = pend_a;
            bus.req_b_i = pend_b;

            if (n >= free_at && (pend_a || pend_b)) begin
                pick_b     = (pend_a && pend_b) ? !model_last_b : pend_b;
                old_frame  = new_frame;
                old_g      = new_g;
                new_g      = pick_b;
                new_frame  = pick_b ? {4'b1111, bus.din_b_i} : {4'b1011, bus.din_a_i};
                strw_at    = n + 1;
                wait_start = n + 2;
                if ($urandom_range(0, 5) == 0) begin
                    eow_plan  = -1;
                    ack_at    = wait_start + TMAX_I + 1;
                    model_err = 1'b1;
                end else begin
                    eow_plan  = wait_start + int'($urandom_range(0, TMAX_I));
                    ack_at    = eow_plan + 1;
                    model_err = 1'b0;
                end
                free_at      = ack_at + 1;
                model_last_b = pick_b;
            end

            in_wait   = (n >= wait_start) && (n < ack_at);
            bus.eow_i = (n == eow_plan) || (!in_wait && $urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
